// File: rtl/multicycle_sequencer.sv
// Multi-cycle PC and control sequencer: steps each instruction through IF/ID/EXE/MEM/WB,
// gates issue with run/single-step controls and counts retired instructions.
module multicycle_sequencer #(
    parameter int unsigned        ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
    parameter int unsigned        CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_en,
    input  logic              step_mode,
    input  logic              step_req,
    input  logic              is_halt,
    input  logic              is_jump,
    input  logic              is_branch,
    input  logic              is_load,
    input  logic              is_store,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] baddr,
    input  logic [ADDR_W-1:0] jaddr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4,
    output logic [2:0]        state,
    output logic              ir_we,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              rf_we,
    output logic              retire,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EXE  = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_pc;
    logic [CNT_W-1:0]   r_cnt;

    logic [ADDR_W-1:0]  w_pc4;
    logic [ADDR_W-1:0]  w_pc_next;
    logic               w_retire;
    logic               w_issue;
    logic               w_cont;

    assign w_pc4   = r_pc + ADDR_W'(4);
    assign w_issue = run_en & (~step_mode | step_req);
    assign w_cont  = run_en & ~step_mode;

    // Strobes decode only registered state plus the held class inputs.
    always_comb begin
        w_retire  = 1'b0;
        w_pc_next = w_pc4;
        unique case (r_state)
            S_ID: begin
                if (~is_halt & is_jump) begin
                    w_retire  = 1'b1;
                    w_pc_next = jaddr;
                end
            end
            S_EXE: begin
                if (is_branch) begin
                    w_retire  = 1'b1;
                    w_pc_next = branch_taken ? baddr : w_pc4;
                end
            end
            S_MEM:   w_retire = ~is_load;
            S_WB:    w_retire = 1'b1;
            default: w_retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_VEC;
            r_cnt   <= '0;
        end else if (w_retire) begin
            r_state <= w_cont ? S_IF : S_IDLE;
            r_pc    <= w_pc_next;
            r_cnt   <= r_cnt + CNT_W'(1);
        end else begin
            unique case (r_state)
                S_IDLE:  if (w_issue) r_state <= S_IF;
                S_IF:    r_state <= S_ID;
                S_ID:    r_state <= is_halt ? S_HALT : S_EXE;
                S_EXE:   r_state <= (is_load | is_store) ? S_MEM : S_WB;
                S_MEM:   r_state <= S_WB;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pc          = r_pc;
    assign pc4         = w_pc4;
    assign state       = r_state;
    assign ir_we       = (r_state == S_IF);
    assign mem_rd      = (r_state == S_MEM) & is_load;
    assign mem_wr      = (r_state == S_MEM) & ~is_load & is_store;
    assign rf_we       = (r_state == S_WB);
    assign retire      = w_retire;
    assign halted      = (r_state == S_HALT);
    assign retired_cnt = r_cnt;

endmodule
